// File: rtl/pipe_mem_pkg.sv
// pipe_mem_pkg: shared types and constants for the M-stage memory access block.
//   - FSM state encoding (legacy localparams plus a typed enum built on them)
//   - default ack timeout, byte-offset width, wait counter width
//   - MEM/WB register payload struct
//   - misalignment helper
package pipe_mem_pkg;

    localparam int TIMEOUT_DEF = 255;
    localparam int OFFS_W      = 2;   // byte-offset bits of a word address
    localparam int CNT_W       = 8;   // wait counter width

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef enum logic [0:0] {
        MS_IDLE = ST_IDLE,
        MS_BUSY = ST_BUSY
    } mem_state_e;

    // Everything the WB stage receives from MEM in one cycle.
    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic [31:0] mo;
        logic [31:0] alu;
        logic [4:0]  rn;
        logic        align_err;
        logic        bus_err;
    } wb_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[OFFS_W-1:0] != '0;
    endfunction

endpackage

// File: rtl/pipe_mw_reg.sv
// pipe_mw_reg: MEM/WB pipeline register.
//   clk   : clock, rising edge
//   clrn  : asynchronous active-high reset, clears the whole payload
//   load  : 1 = capture d, 0 = insert a bubble (all-zero payload)
//   d     : payload offered by the MEM stage
//   q     : registered payload seen by WB
module pipe_mw_reg
    import pipe_mem_pkg::*;
(
    input  logic clk,
    input  logic clrn,
    input  logic load,
    input  wb_t  d,
    output wb_t  q
);

    wb_t wb_d;
    wb_t wb_q;

    always_comb begin
        wb_d = load ? d : '0;
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign q = wb_q;

endmodule

// File: rtl/pipe_mem_access.sv
// pipe_mem_access: M stage of the pipeline with a registered data-memory port.
//   clk, clrn                  : clock / asynchronous active-high reset
//   mwreg, mm2reg, mwmem       : M-stage control (regfile write, load, store)
//   malu, mb, mrn              : address/ALU result, store data, destination
//   mem_req/we/addr/wdata      : registered request, held for the whole access
//   mem_rdata, mem_ack         : response, ack is a one-cycle pulse
//   mstall                     : combinational hold for upstream registers
//   wwreg, wm2reg, wmo, walu,
//   wrn, walign_err, wbus_err  : MEM/WB register outputs
//   dbg_state                  : current FSM state
//
// Handshake: an access is requested by holding mem_req high with constant
// we/addr/wdata until the first cycle mem_ack is seen; that cycle completes
// the access and mem_req drops on the next edge. If no ack arrives within
// TIMEOUT+1 busy cycles the access is abandoned and flagged as a bus error.
module pipe_mem_access
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mstall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        walign_err,
    output logic        wbus_err,
    output mem_state_e  dbg_state
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    mem_state_e        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              req_d, req_q;
    logic              we_d, we_q;
    logic [31:0]       addr_d, addr_q;
    logic [31:0]       wdata_d, wdata_q;

    logic access;
    logic misaligned;
    logic stall_c;
    logic wb_load;
    wb_t  wb_in;
    wb_t  wb_out;

    assign access     = mm2reg | mwmem;
    assign misaligned = access & is_misaligned(malu);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        stall_c = 1'b0;
        wb_load = 1'b0;

        // Load+store together is treated as a store, so never a WB load.
        wb_in.wreg      = mwreg;
        wb_in.m2reg     = mm2reg & ~mwmem;
        wb_in.mo        = '0;
        wb_in.alu       = malu;
        wb_in.rn        = mrn;
        wb_in.align_err = 1'b0;
        wb_in.bus_err   = 1'b0;

        case (state_q)
            MS_IDLE: begin
                // mem_ack is deliberately not looked at here.
                if (!access) begin
                    wb_load = 1'b1;
                end else if (misaligned) begin
                    wb_load         = 1'b1;
                    wb_in.wreg      = 1'b0;
                    wb_in.m2reg     = 1'b0;
                    wb_in.align_err = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    we_d    = mwmem;
                    addr_d  = malu;
                    wdata_d = mb;
                    cnt_d   = '0;
                    state_d = MS_BUSY;
                end
            end
            MS_BUSY: begin
                // Ack wins over a timeout landing in the same cycle.
                if (mem_ack) begin
                    wb_load  = 1'b1;
                    wb_in.mo = mwmem ? '0 : mem_rdata;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    state_d  = MS_IDLE;
                end else if (cnt_q == TO_CNT) begin
                    wb_load       = 1'b1;
                    wb_in.wreg    = 1'b0;
                    wb_in.m2reg   = 1'b0;
                    wb_in.bus_err = 1'b1;
                    req_d         = 1'b0;
                    we_d          = 1'b0;
                    addr_d        = '0;
                    wdata_d       = '0;
                    state_d       = MS_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    pipe_mw_reg u_mw_reg (
        .clk  (clk),
        .clrn (clrn),
        .load (wb_load),
        .d    (wb_in),
        .q    (wb_out)
    );

    // Reset must also release the upstream pipeline immediately.
    assign mstall     = stall_c & ~clrn;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign wwreg      = wb_out.wreg;
    assign wm2reg     = wb_out.m2reg;
    assign wmo        = wb_out.mo;
    assign walu       = wb_out.alu;
    assign wrn        = wb_out.rn;
    assign walign_err = wb_out.align_err;
    assign wbus_err   = wb_out.bus_err;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipe_mem_access.sv
// tb_pipe_mem_access: directed and randomized checks of pipe_mem_access
// with TIMEOUT=4, against a per-instruction outcome model.
module tb_pipe_mem_access;
    import pipe_mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mstall;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;
    logic        walign_err, wbus_err;
    mem_state_e  dbg_state;

    int n_vec = 0;
    int n_bad = 0;

    pipe_mem_access #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .malu       (malu),
        .mb         (mb),
        .mrn        (mrn),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mstall     (mstall),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wmo        (wmo),
        .walu       (walu),
        .wrn        (wrn),
        .walign_err (walign_err),
        .wbus_err   (wbus_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bubble(input string tag);
        chk1({tag, "_wwreg"}, wwreg, 1'b0);
        chk1({tag, "_wm2reg"}, wm2reg, 1'b0);
        chk1({tag, "_walign"}, walign_err, 1'b0);
        chk1({tag, "_wbus"}, wbus_err, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_req"}, mem_req, 1'b0);
        chk1({tag, "_we"}, mem_we, 1'b0);
        chk32({tag, "_addr"}, mem_addr, 32'h0);
        chk32({tag, "_wdata"}, mem_wdata, 32'h0);
        chk1({tag, "_wwreg"}, wwreg, 1'b0);
        chk1({tag, "_wm2reg"}, wm2reg, 1'b0);
        chk32({tag, "_wmo"}, wmo, 32'h0);
        chk32({tag, "_walu"}, walu, 32'h0);
        chk32({tag, "_wrn"}, 32'(wrn), 32'h0);
        chk1({tag, "_walign"}, walign_err, 1'b0);
        chk1({tag, "_wbus"}, wbus_err, 1'b0);
        chk1({tag, "_mstall"}, mstall, 1'b0);
        chk1({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // One M-stage instruction, from presentation to WB result.
    // ack_k: busy cycle (0 = first cycle mem_req is high) in which mem_ack
    // pulses; any value above TO means the memory never answers.
    task automatic do_instr(input logic wreg, input logic m2reg, input logic wmem,
                            input logic [31:0] alu, input logic [31:0] b,
                            input logic [4:0] rn, input int ack_k,
                            input logic [31:0] rdata);
        logic acc, mis, done, tout;
        acc = m2reg | wmem;
        mis = acc && (alu[1:0] != 2'b00);
        @(negedge clk);
        mwreg  = wreg;
        mm2reg = m2reg;
        mwmem  = wmem;
        malu   = alu;
        mb     = b;
        mrn    = rn;
        // Acks seen while idle must be ignored.
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        if (!acc || mis) begin
            chk1("idle_mstall", mstall, 1'b0);
            @(posedge clk);
            #1;
            chk1("pass_wwreg", wwreg, mis ? 1'b0 : wreg);
            chk1("pass_wm2reg", wm2reg, 1'b0);
            chk32("pass_wmo", wmo, 32'h0);
            chk32("pass_walu", walu, alu);
            chk32("pass_wrn", 32'(wrn), 32'(rn));
            chk1("pass_walign", walign_err, mis);
            chk1("pass_wbus", wbus_err, 1'b0);
            chk1("pass_req", mem_req, 1'b0);
        end else begin
            chk1("start_mstall", mstall, 1'b1);
            @(posedge clk);
            #1;
            chk1("start_req", mem_req, 1'b1);
            chk1("start_we", mem_we, wmem);
            chk32("start_addr", mem_addr, alu);
            chk32("start_wdata", mem_wdata, b);
            chk1("start_state", dbg_state, ST_BUSY);
            chk_bubble("start");
            for (int k = 0; k <= TO; k++) begin
                done = (k == ack_k);
                tout = (k == TO) && !done;
                @(negedge clk);
                mem_ack   = done;
                mem_rdata = done ? rdata : $urandom;
                #1;
                chk1("busy_mstall", mstall, !(done || tout));
                @(posedge clk);
                #1;
                if (done) begin
                    chk1("done_wwreg", wwreg, wreg);
                    chk1("done_wm2reg", wm2reg, m2reg & ~wmem);
                    chk32("done_wmo", wmo, wmem ? 32'h0 : rdata);
                    chk32("done_walu", walu, alu);
                    chk32("done_wrn", 32'(wrn), 32'(rn));
                    chk1("done_walign", walign_err, 1'b0);
                    chk1("done_wbus", wbus_err, 1'b0);
                    chk1("done_req", mem_req, 1'b0);
                    chk1("done_we", mem_we, 1'b0);
                    chk1("done_state", dbg_state, ST_IDLE);
                    break;
                end else if (tout) begin
                    chk1("tout_wwreg", wwreg, 1'b0);
                    chk1("tout_wm2reg", wm2reg, 1'b0);
                    chk1("tout_wbus", wbus_err, 1'b1);
                    chk1("tout_walign", walign_err, 1'b0);
                    chk1("tout_req", mem_req, 1'b0);
                    chk1("tout_state", dbg_state, ST_IDLE);
                    break;
                end else begin
                    chk1("hold_req", mem_req, 1'b1);
                    chk1("hold_we", mem_we, wmem);
                    chk32("hold_addr", mem_addr, alu);
                    chk32("hold_wdata", mem_wdata, b);
                    chk_bubble("hold");
                end
            end
        end
    endtask

    initial begin
        logic        r_wreg, r_m2reg, r_wmem;
        logic [31:0] r_alu;
        int          kind;

        clrn      = 1'b1;
        mwreg     = 1'b0;
        mm2reg    = 1'b0;
        mwmem     = 1'b0;
        malu      = 32'h0;
        mb        = 32'h0;
        mrn       = 5'd0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        clrn = 1'b0;

        // ALU op passes straight through.
        do_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        // Load acked in the fourth busy cycle.
        do_instr(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        // Store acked immediately.
        do_instr(1'b0, 1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, 5'd0, 0, 32'h0);
        // Misaligned load.
        do_instr(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd9, 0, 32'h0);
        // Load never acked.
        do_instr(1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd3, 99, 32'h0);
        // Ack coincides with the timeout cycle.
        do_instr(1'b1, 1'b1, 1'b0, 32'h208, 32'h0, 5'd4, TO, 32'h13579BDF);
        // Load and store together behave as a store.
        do_instr(1'b1, 1'b1, 1'b1, 32'h20C, 32'h0BADF00D, 5'd6, 1, 32'hFFFFFFFF);

        // Reset in the middle of a busy access.
        @(negedge clk);
        mwreg  = 1'b1;
        mm2reg = 1'b1;
        mwmem  = 1'b0;
        malu   = 32'h300;
        mrn    = 5'd11;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk1("rst_pre_req", mem_req, 1'b1);
        @(negedge clk);
        #2;
        clrn    = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        clrn      = 1'b0;
        mwreg     = 1'b0;
        mm2reg    = 1'b0;
        mwmem     = 1'b0;
        malu      = 32'h0;
        mrn       = 5'd0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        chk1("late_ack_mstall", mstall, 1'b0);
        @(posedge clk);
        #1;
        chk1("late_ack_req", mem_req, 1'b0);
        chk32("late_ack_wmo", wmo, 32'h0);
        chk1("late_ack_wwreg", wwreg, 1'b0);
        chk1("late_ack_state", dbg_state, ST_IDLE);

        // Random mix, issued back to back.
        for (int i = 0; i < 200; i++) begin
            kind    = int'($urandom_range(0, 3));
            r_wreg  = 1'($urandom_range(0, 1));
            r_m2reg = (kind == 1) || (kind == 3);
            r_wmem  = (kind == 2) || (kind == 3);
            r_alu   = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) begin
                r_alu[1:0] = 2'($urandom_range(1, 3));
            end
            do_instr(r_wreg, r_m2reg, r_wmem, r_alu, $urandom, 5'($urandom_range(0, 31)),
                     int'($urandom_range(0, TO + 2)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_mem_access.md
PIPE_MEM_ACCESS -- requirements
Module: pipe_mem_access

Interface
REQ-001 SHALL have: clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have: clrn  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have: mwreg, mm2reg, mwmem  input  1 each  M-stage control (regfile write, load, store).
REQ-004 SHALL have: malu  input  32  M-stage address/ALU result; mb  input  32  store data; mrn  input  5  destination register.
REQ-005 SHALL have: mem_req  output  1; mem_we  output  1; mem_addr  output  32; mem_wdata  output  32  registered data-memory request.
REQ-006 SHALL have: mem_rdata  input  32; mem_ack  input  1  memory response, single-cycle pulse.
REQ-007 SHALL have: mstall  output  1  combinational hold for upstream pipeline registers.
REQ-008 SHALL have: wwreg, wm2reg  output  1; wmo, walu  output  32; wrn  output  5  MEM/WB register outputs.
REQ-009 SHALL have: walign_err, wbus_err  output  1  registered exception flags travelling with WB.
REQ-010 SHALL have: parameter TIMEOUT, default 255, max wait cycles for mem_ack.

Function
REQ-011 SHALL be a two-state FSM, IDLE and BUSY, plus an 8-bit wait counter.
REQ-012 Access = mm2reg|mwmem; misaligned = access & (malu[1:0]!=0); both mm2reg and mwmem high SHALL count as a store with wm2reg forced 0.
REQ-013 IDLE, no access: mstall=0; WB loads mwreg,mm2reg,malu,mrn next edge; wmo=0; latency 1 cycle.
REQ-014 IDLE, misaligned: no request, mstall=0; WB loads wwreg=0, wm2reg=0, walign_err=1.
REQ-015 IDLE, aligned access: mstall=1; next edge mem_req=1, mem_we=mwmem, mem_addr=malu, mem_wdata=mb, counter=0, state BUSY; WB loads bubble (wwreg=0, wm2reg=0, flags 0).
REQ-016 BUSY: mem_req/we/addr/wdata SHALL stay constant; mstall = !mem_ack; WB loads bubble each stalled cycle; counter increments.
REQ-017 BUSY & mem_ack: WB loads mwreg, mm2reg, malu, mrn, wmo=mem_rdata (0 for stores); mem_req=0 and state IDLE next edge; minimum memory-op latency 2 cycles.
REQ-018 BUSY & counter==TIMEOUT & !mem_ack: abort; mstall=0; WB loads wwreg=0, wm2reg=0, wbus_err=1; mem_req=0, state IDLE.
REQ-019 mem_ack SHALL be ignored in IDLE; mem_ack and timeout in the same cycle SHALL complete normally.
REQ-020 Back-to-back accesses: the instruction arriving the cycle after completion SHALL be evaluated in IDLE normally, with no idle gap required.

Reset
REQ-021 clrn high SHALL immediately force state IDLE, counter 0, and all outputs except mstall to 0, including mem_req mid-transaction.
REQ-022 While clrn is high, mstall SHALL be 0; a late mem_ack SHALL have no effect.

Structure
REQ-023 Shared package pipe_mem_pkg SHALL hold the state enum, the TIMEOUT default and the byte-offset width constant.
REQ-024 The MEM/WB register SHALL be a sub-module pipe_mw_reg with a bubble/load select, used by pipe_mem_access.

Verification
REQ-025 ALU op mwreg=1, malu=0x1234, mrn=5 -> next cycle wwreg=1, walu=0x1234, wrn=5, mstall never high.
REQ-026 Load malu=0x100, ack 3 cycles after mem_req with rdata=0xDEADBEEF -> mstall high 4 cycles, then wmo=0xDEADBEEF, wm2reg=1, mem_req low the next cycle.
REQ-027 Store malu=0x104, mb=0xA5A5A5A5, ack immediately -> mem_we=1, mem_wdata=0xA5A5A5A5 for 1 cycle, wwreg=0, 2-cycle total.
REQ-028 Load malu=0x102 -> no mem_req, walign_err=1, wwreg=0, mstall=0.
REQ-029 Load with no ack, TIMEOUT=4 -> after 5 BUSY cycles wbus_err=1, mem_req=0, FSM IDLE.
REQ-030 clrn pulsed during BUSY -> mem_req and all W outputs 0 asynchronously; an ack after release is ignored.
